sign_mag_add_pipe: RTL and testbench

Pipelined, parametrised sign-magnitude adder/subtractor with valid/ready flow control on both sides. Accepts one pair of N-bit sign-magnitude operands per cycle, plus an add/subtract select. Returns a normalised sign-magnitude result with an overflow flag two cycles later. It is the clocked, back-pressurable successor to the combinational sign-magnitude adder and sits between operand sources and sign-magnitude consumers in the datapath.

---
 rtl/sign_mag_add_pipe.sv | 156 +++++++++++++++
 tb/tb_sign_mag_add_pipe.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sign_mag_add_pipe.sv
// sign_mag_add_pipe
//   Two-stage pipelined sign-magnitude adder/subtractor with valid/ready
//   flow control on both sides. Stage S1 orders the operand magnitudes and
//   picks the result sign; stage S2 adds or subtracts the magnitudes,
//   saturates or wraps on overflow and normalises -0 to +0.
//
// Parameters
//   N    total width including sign bit (MSB = sign), N >= 3
//   SAT  1: saturate magnitude on overflow, 0: keep low N-1 bits
//
// Ports
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   in_valid   operand pair present        in_ready   operands accepted
//   a, b       sign-magnitude operands      sub        0: a+b, 1: a-b
//   out_valid  result present               out_ready  consumer takes result
//   sum        sign-magnitude result        ovf        magnitude overflow
module sign_mag_add_pipe #(
   parameter int N   = 8,
   parameter bit SAT = 1'b1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] sum,
   output logic         ovf
);

   localparam int M = N - 1;

   // Overflowed magnitudes either clamp to full scale or keep the low bits.
   function automatic logic [M-1:0] sat_mag(input logic carry, input logic [M-1:0] raw);
      if (carry && SAT) begin
         sat_mag = {M{1'b1}};
      end else begin
         sat_mag = raw;
      end
   endfunction

   logic         s1_valid_q, s1_valid_d;
   logic [M-1:0] s1_max_q, s1_max_d;
   logic [M-1:0] s1_min_q, s1_min_d;
   logic         s1_sign_q, s1_sign_d;
   logic         s1_eff_sub_q, s1_eff_sub_d;

   logic         s2_valid_q, s2_valid_d;
   logic         s2_sign_q, s2_sign_d;
   logic [M-1:0] s2_mag_q, s2_mag_d;
   logic         s2_ovf_q, s2_ovf_d;

   logic         s2_load;
   logic         in_xfer;
   logic [M-1:0] mag_a, mag_b;
   logic         sign_a, sign_b;
   logic         a_ge_b;
   logic [M:0]   add_full;
   logic [M-1:0] res_mag;
   logic         res_ovf;

   // Flow control: in_ready looks through to out_ready so a full pipe
   // can exchange one result for one operand pair every cycle.
   always_comb begin
      s2_load  = !s2_valid_q || out_ready;
      in_ready = reset_n && (!s1_valid_q || s2_load);
      in_xfer  = in_valid && in_ready;
   end

   // ---- input -> S1: compare magnitudes, choose result sign ----
   always_comb begin
      mag_a  = a[M-1:0];
      mag_b  = b[M-1:0];
      // A zero magnitude is always taken as positive, so -0 behaves as +0.
      sign_a = a[M] && (mag_a != '0);
      sign_b = (b[M] ^ sub) && (mag_b != '0);
      // Ties go to A so equal magnitudes take A's sign.
      a_ge_b = (mag_a >= mag_b);

      s1_valid_d   = s1_valid_q;
      s1_max_d     = s1_max_q;
      s1_min_d     = s1_min_q;
      s1_sign_d    = s1_sign_q;
      s1_eff_sub_d = s1_eff_sub_q;

      if (s2_load) begin
         s1_valid_d = 1'b0;
      end
      if (in_xfer) begin
         s1_valid_d   = 1'b1;
         s1_max_d     = a_ge_b ? mag_a : mag_b;
         s1_min_d     = a_ge_b ? mag_b : mag_a;
         s1_sign_d    = a_ge_b ? sign_a : sign_b;
         s1_eff_sub_d = (sign_a != sign_b);
      end
   end

   // ---- S1 -> S2: magnitude add/subtract, overflow, zero normalisation ----
   always_comb begin
      add_full = {1'b0, s1_max_q} + {1'b0, s1_min_q};
      // max >= min, so the difference never borrows.
      res_mag  = s1_max_q - s1_min_q;
      res_ovf  = 1'b0;
      if (!s1_eff_sub_q) begin
         res_ovf = add_full[M];
         res_mag = sat_mag(add_full[M], add_full[M-1:0]);
      end

      s2_valid_d = s2_valid_q;
      s2_sign_d  = s2_sign_q;
      s2_mag_d   = s2_mag_q;
      s2_ovf_d   = s2_ovf_q;

      if (s2_load) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_sign_d = s1_sign_q && (res_mag != '0);
            s2_mag_d  = res_mag;
            s2_ovf_d  = res_ovf;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_valid_q   <= 1'b0;
         s1_max_q     <= '0;
         s1_min_q     <= '0;
         s1_sign_q    <= 1'b0;
         s1_eff_sub_q <= 1'b0;
         s2_valid_q   <= 1'b0;
         s2_sign_q    <= 1'b0;
         s2_mag_q     <= '0;
         s2_ovf_q     <= 1'b0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_max_q     <= s1_max_d;
         s1_min_q     <= s1_min_d;
         s1_sign_q    <= s1_sign_d;
         s1_eff_sub_q <= s1_eff_sub_d;
         s2_valid_q   <= s2_valid_d;
         s2_sign_q    <= s2_sign_d;
         s2_mag_q     <= s2_mag_d;
         s2_ovf_q     <= s2_ovf_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign sum       = {s2_sign_q, s2_mag_q};
   assign ovf       = s2_ovf_q;

endmodule

// File: tb/tb_sign_mag_add_pipe.sv
// tb_sign_mag_add_pipe
//   Bench for sign_mag_add_pipe. Four instances share one stimulus stream:
//   N=8/SAT=1, N=8/SAT=0, N=5/SAT=1, N=5/SAT=0. Directed vectors carry
//   hand-computed results; an in-order scoreboard with a signed-integer
//   reference model follows every instance throughout the run.
module tb_sign_mag_add_pipe;

   logic       clk;
   logic       reset_n;
   logic       in_valid;
   logic       out_ready;
   logic [7:0] a, b;
   logic       sub;

   wire [3:0]  irdy;
   wire [3:0]  ovld;
   wire [3:0]  ovf_o;
   wire [7:0]  sum_o [4];
   wire [4:0]  s5_sat, s5_wrap;

   assign sum_o[2] = {3'b000, s5_sat};
   assign sum_o[3] = {3'b000, s5_wrap};

   sign_mag_add_pipe #(.N(8), .SAT(1'b1)) u_n8_sat (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(irdy[0]),
      .a(a), .b(b), .sub(sub), .out_valid(ovld[0]), .out_ready(out_ready),
      .sum(sum_o[0]), .ovf(ovf_o[0]));

   sign_mag_add_pipe #(.N(8), .SAT(1'b0)) u_n8_wrap (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(irdy[1]),
      .a(a), .b(b), .sub(sub), .out_valid(ovld[1]), .out_ready(out_ready),
      .sum(sum_o[1]), .ovf(ovf_o[1]));

   sign_mag_add_pipe #(.N(5), .SAT(1'b1)) u_n5_sat (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(irdy[2]),
      .a(a[4:0]), .b(b[4:0]), .sub(sub), .out_valid(ovld[2]), .out_ready(out_ready),
      .sum(s5_sat), .ovf(ovf_o[2]));

   sign_mag_add_pipe #(.N(5), .SAT(1'b0)) u_n5_wrap (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(irdy[3]),
      .a(a[4:0]), .b(b[4:0]), .sub(sub), .out_valid(ovld[3]), .out_ready(out_ready),
      .sum(s5_wrap), .ovf(ovf_o[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic       sub;
   } op_t;

   op_t        ops[$];
   int         rd [4];
   logic       hold_pend [4];
   logic [7:0] hold_sum [4];
   logic       hold_ovf [4];
   int         n_chk;
   int         n_fail;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: evaluate as signed integers, then encode back to sign-magnitude.
   function automatic logic [8:0] ref_res(input int n, input bit sat, input op_t op);
      int m, maxm, ma, mb, va, vb, r, mag;
      bit sgn, ov;
      m    = n - 1;
      maxm = (1 << m) - 1;
      ma   = int'(op.a) & maxm;
      mb   = int'(op.b) & maxm;
      va   = op.a[m] ? -ma : ma;
      vb   = op.b[m] ? -mb : mb;
      r    = op.sub ? (va - vb) : (va + vb);
      mag  = (r < 0) ? -r : r;
      ov   = (mag > maxm);
      if (ov) mag = sat ? maxm : (mag & maxm);
      sgn  = (r < 0) && (mag != 0);
      return {ov, 8'(mag | (sgn ? (1 << m) : 0))};
   endfunction

   function automatic int dut_n(input int d);
      return (d < 2) ? 8 : 5;
   endfunction

   // One clock cycle. Caller has set inputs; handshake and scoreboard are
   // evaluated before the edge, scoreboard state is flushed by reset.
   task automatic cyc();
      op_t        o;
      logic [8:0] e;
      #1;
      if (reset_n) begin
         for (int d = 0; d < 4; d++) begin
            if (hold_pend[d]) begin
               check($sformatf("hold_vld[%0d]", d), ovld[d], 1);
               check($sformatf("hold_sum[%0d]", d), sum_o[d], hold_sum[d]);
               check($sformatf("hold_ovf[%0d]", d), ovf_o[d], hold_ovf[d]);
            end
            hold_pend[d] = ovld[d] && !out_ready;
            hold_sum[d]  = sum_o[d];
            hold_ovf[d]  = ovf_o[d];
            if (ovld[d]) begin
               if (rd[d] >= ops.size()) begin
                  check($sformatf("stale_vld[%0d]", d), ovld[d], 0);
               end else if (out_ready) begin
                  e = ref_res(dut_n(d), (d % 2) == 0, ops[rd[d]]);
                  check($sformatf("sb_sum[%0d]", d), sum_o[d], e[7:0]);
                  check($sformatf("sb_ovf[%0d]", d), ovf_o[d], e[8]);
                  rd[d]++;
               end
            end
         end
         if (in_valid && irdy[0]) begin
            o.a = a; o.b = b; o.sub = sub;
            ops.push_back(o);
         end
      end
      @(posedge clk);
      if (!reset_n) begin
         ops.delete();
         for (int d = 0; d < 4; d++) begin
            rd[d] = 0;
            hold_pend[d] = 1'b0;
         end
      end
      #1;
   endtask

   logic [7:0] ba [5] = '{8'h05, 8'h05, 8'h85, 8'h80, 8'h03};
   logic [7:0] bb [5] = '{8'h03, 8'h87, 8'h85, 8'h80, 8'h05};
   logic       bs [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [7:0] be [5] = '{8'h08, 8'h82, 8'h00, 8'h00, 8'h82};

   logic [7:0] oa [4]  = '{8'h64, 8'hE4, 8'h40, 8'h64};
   logic [7:0] ob [4]  = '{8'h32, 8'hB2, 8'h40, 8'h32};
   logic       os [4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
   logic [7:0] oes [4] = '{8'h7F, 8'hFF, 8'h7F, 8'h32};
   logic [7:0] oew [4] = '{8'h16, 8'h96, 8'h00, 8'h32};
   logic       eov [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

   logic [7:0] pa [4]  = '{8'h01, 8'h02, 8'h07, 8'h81};
   logic [7:0] pb [4]  = '{8'h01, 8'h01, 8'h01, 8'h01};
   logic       ps [4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
   logic [7:0] pe [4]  = '{8'h02, 8'h03, 8'h06, 8'h00};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         idx, ng, acc, cyc_n;
      logic [7:0] snap;
      logic [7:0] got [4];

      n_chk = 0;
      n_fail = 0;
      for (int d = 0; d < 4; d++) begin
         rd[d] = 0;
         hold_pend[d] = 1'b0;
      end

      // Reset with traffic offered on both sides.
      reset_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      a = 8'h05; b = 8'h03; sub = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("rst_in_ready", irdy[0], 0);
         cyc();
      end
      for (int d = 0; d < 4; d++) begin
         check($sformatf("rst_out_valid[%0d]", d), ovld[d], 0);
         check($sformatf("rst_sum[%0d]", d), sum_o[d], 0);
         check($sformatf("rst_ovf[%0d]", d), ovf_o[d], 0);
      end
      reset_n = 1'b1; in_valid = 1'b0;
      #1;
      check("rel_in_ready", irdy[0], 1);
      cyc();
      for (int i = 0; i < 2; i++) begin
         check("rel_no_accept", ovld[0], 0);
         cyc();
      end

      // Basic arithmetic, streamed back to back.
      for (int c = 0; c < 7; c++) begin
         in_valid = (c < 5);
         if (c < 5) begin a = ba[c]; b = bb[c]; sub = bs[c]; end
         #1;
         if (c < 5) check("basic_in_ready", irdy[0], 1);
         if (c >= 2) begin
            check("basic_vld", ovld[0], 1);
            check("basic_sum", sum_o[0], be[c-2]);
            check("basic_ovf", ovf_o[0], 0);
         end else begin
            check("basic_vld_early", ovld[0], 0);
         end
         cyc();
      end

      // Overflow: saturate vs wrap.
      for (int c = 0; c < 6; c++) begin
         in_valid = (c < 4);
         if (c < 4) begin a = oa[c]; b = ob[c]; sub = os[c]; end
         #1;
         if (c >= 2) begin
            check("ovf_sat_sum", sum_o[0], oes[c-2]);
            check("ovf_sat_flag", ovf_o[0], eov[c-2]);
            check("ovf_wrap_sum", sum_o[1], oew[c-2]);
            check("ovf_wrap_flag", ovf_o[1], eov[c-2]);
         end
         cyc();
      end

      // Back-pressure: four pairs offered with the consumer stalled.
      idx = 0; out_ready = 1'b0; snap = 8'h00;
      for (int c = 0; c < 6; c++) begin
         in_valid = (idx < 4);
         if (idx < 4) begin a = pa[idx]; b = pb[idx]; sub = ps[idx]; end
         #1;
         if (in_valid && irdy[0]) idx++;
         if (c == 2) snap = sum_o[0];
         cyc();
      end
      check("bp_accepted", idx, 2);
      check("bp_in_ready_low", irdy[0], 0);
      check("bp_out_valid", ovld[0], 1);
      check("bp_sum_stable", sum_o[0], snap);
      out_ready = 1'b1; ng = 0;
      for (int c = 0; c < 12 && ng < 4; c++) begin
         in_valid = (idx < 4);
         if (idx < 4) begin a = pa[idx]; b = pb[idx]; sub = ps[idx]; end
         #1;
         if (c == 0) check("bp_in_ready_rise", irdy[0], 1);
         if (ovld[0] && out_ready) begin
            got[ng] = sum_o[0];
            ng++;
         end
         if (in_valid && irdy[0]) idx++;
         cyc();
      end
      check("bp_count", ng, 4);
      for (int i = 0; i < 4; i++) check($sformatf("bp_order[%0d]", i), got[i], pe[i]);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) cyc();

      // Random stalls on both sides; all four instances scoreboarded.
      acc = 0; cyc_n = 0;
      while (acc < 10000 && cyc_n < 60000) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         a   = 8'($urandom);
         b   = 8'($urandom);
         sub = 1'($urandom_range(0, 1));
         #1;
         if (in_valid && irdy[0]) acc++;
         cyc();
         cyc_n++;
      end
      check("rand_accepted", acc, 10000);
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) cyc();
      for (int d = 0; d < 4; d++) check($sformatf("rand_drained[%0d]", d), rd[d], ops.size());

      // Reset while both stages hold data.
      out_ready = 1'b0; in_valid = 1'b1; a = 8'h11; b = 8'h22; sub = 1'b0;
      cyc();
      cyc();
      in_valid = 1'b0;
      #1;
      check("mr_full", ovld[0], 1);
      reset_n = 1'b0;
      cyc();
      for (int d = 0; d < 4; d++) check($sformatf("mr_vld_clr[%0d]", d), ovld[d], 0);
      reset_n = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("mr_no_stale", ovld[0], 0);
         cyc();
      end
      in_valid = 1'b1; a = 8'h05; b = 8'h03; sub = 1'b0;
      cyc();
      in_valid = 1'b0;
      check("mr_lat1", ovld[0], 0);
      cyc();
      check("mr_lat2_vld", ovld[0], 1);
      check("mr_lat2_sum", sum_o[0], 8'h08);
      cyc();
      check("mr_done", ovld[0], 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
